// File: rtl/instr_fetch_if.sv
// Instruction-bus read channel between the fetch stage and instruction memory.
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns PC, reads instruction words over ibus, holds IR and decode fields.
// FETCH_MISALIGN_CHECK_EN enables misaligned-fetch detection; otherwise fetch_fault is tied to 0.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic        load_ir,
  input  logic        pc_update,
  input  logic        pc_src,
  input  logic        branch_taken,
  input  logic [31:0] alu_target,
  input  logic [31:0] branch_target,
  instr_fetch_if.master ibus,
  output logic        stall,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [2:0]  f3,
  output logic [6:0]  f7,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] buf_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic        misaligned;
  logic        issue, buf_load, ir_from_bus, ir_from_buf, fault_set;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;

  assign misaligned  = |pc_q[1:0];
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (rst)            fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
  end
`else
  assign misaligned  = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    buf_load    = 1'b0;
    ir_from_bus = 1'b0;
    ir_from_buf = 1'b0;
    fault_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          if (misaligned) begin
            fault_set = 1'b1;
          end else begin
            issue   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (ibus.ack) begin
          if (load_ir) begin
            ir_from_bus = 1'b1;
            state_d     = IDLE;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (load_ir) begin
          ir_from_buf = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus address is captured only at issue, so PC updates mid-transaction leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      addr_q <= 32'h0;
      buf_q  <= 32'h0;
      ir_q   <= NOP;
    end else begin
      if (issue) begin
        req_q  <= 1'b1;
        addr_q <= {pc_q[31:2], 2'b00};
      end else if (ir_from_bus || buf_load) begin
        req_q <= 1'b0;
      end
      if (buf_load)    buf_q <= ibus.rdata;
      if (ir_from_bus) ir_q  <= ibus.rdata;
      if (ir_from_buf) ir_q  <= buf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (pc_update) begin
      if (pc_src)            pc_q <= {alu_target[31:1], 1'b0};
      else if (branch_taken) pc_q <= branch_target;
      else                   pc_q <= pc_q + 32'd4;
    end
  end

  logic unused_alu_lsb;
  assign unused_alu_lsb = alu_target[0];

  assign stall = !rst && ((load_ir && !(state_q == HOLD || (state_q == REQ && ibus.ack)))
                          || fetch_fault);

  assign ibus.req  = req_q;
  assign ibus.addr = addr_q;
  assign pc        = pc_q;
  assign next_pc   = pc_q + 32'd4;
  assign ir        = ir_q;
  assign opcode    = ir_q[6:0];
  assign f3        = ir_q[14:12];
  assign f7        = ir_q[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch: table of per-cycle stimulus with expected outputs.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, fetch_req, load_ir, pc_update, pc_src, branch_taken;
  logic [31:0] alu_target, branch_target;
  logic        stall, fetch_fault;
  logic [31:0] pc, next_pc, ir;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;

  int checks = 0;
  int errors = 0;

  instr_fetch_if ibus_if ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .load_ir(load_ir),
    .pc_update(pc_update), .pc_src(pc_src), .branch_taken(branch_taken),
    .alu_target(alu_target), .branch_target(branch_target), .ibus(ibus_if),
    .stall(stall), .pc(pc), .next_pc(next_pc), .ir(ir), .opcode(opcode),
    .f3(f3), .f7(f7), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, fr, li, pu, ps, bt;
    logic [31:0] alu, btgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall;
    logic [31:0] e_pc, e_ir;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fault;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle; stall is checked before the edge, registered outputs after it.
  task automatic step(input vec_t v, input string tag);
    rst = v.rst; fetch_req = v.fr; load_ir = v.li; pc_update = v.pu;
    pc_src = v.ps; branch_taken = v.bt; alu_target = v.alu; branch_target = v.btgt;
    ibus_if.ack = v.ack; ibus_if.rdata = v.rdata;
    #1;
    chk({tag, " stall"}, {31'b0, stall}, {31'b0, v.e_stall});
    @(posedge clk);
    #1;
    chk({tag, " pc"}, pc, v.e_pc);
    chk({tag, " next_pc"}, next_pc, v.e_pc + 32'd4);
    chk({tag, " ir"}, ir, v.e_ir);
    chk({tag, " opcode"}, {25'b0, opcode}, {25'b0, v.e_ir[6:0]});
    chk({tag, " f3"}, {29'b0, f3}, {29'b0, v.e_ir[14:12]});
    chk({tag, " f7"}, {25'b0, f7}, {25'b0, v.e_ir[31:25]});
    chk({tag, " ibus_req"}, {31'b0, ibus_if.req}, {31'b0, v.e_req});
    chk({tag, " ibus_addr"}, ibus_if.addr, v.e_addr);
    chk({tag, " fetch_fault"}, {31'b0, fetch_fault}, {31'b0, v.e_fault});
  endtask

  initial begin
    //          rst fr li pu ps bt alu           btgt          ack rdata         stl pc            ir            req addr          flt
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        NOP,          0, 32'h0,        0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        NOP,          0, 32'h0,        0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        NOP,          1, 32'h0,        0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00500093, 0, 32'h0,        32'h00500093, 0, 32'h0,        0};
    tbl[4]  = '{0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0,        32'h00500093, 0, 32'h0,        0};
    tbl[5]  = '{0, 0, 0, 1, 0, 1, 32'h0,        32'h100,      0, 32'h0,        0, 32'h100,      32'h00500093, 0, 32'h0,        0};
    tbl[6]  = '{0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h104,      32'h00500093, 0, 32'h0,        0};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h104,      32'h00500093, 1, 32'h104,      0};
    tbl[8]  = '{0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h104,      32'h00500093, 1, 32'h104,      0};
    tbl[9]  = '{0, 0, 1, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h108,      32'h00500093, 1, 32'h104,      0};
    tbl[10] = '{0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h108,      32'h00500093, 1, 32'h104,      0};
    tbl[11] = '{0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00A00113, 0, 32'h108,      32'h00A00113, 0, 32'h104,      0};
    tbl[12] = '{0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h108,      32'h00A00113, 1, 32'h108,      0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h4020D1B3, 0, 32'h108,      32'h00A00113, 0, 32'h108,      0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hDEADBEEF, 0, 32'h108,      32'h00A00113, 0, 32'h108,      0};
    tbl[15] = '{0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h108,      32'h4020D1B3, 0, 32'h108,      0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'hFFFFFFFF, 0, 32'h108,      32'h4020D1B3, 0, 32'h108,      0};
    tbl[17] = '{0, 0, 0, 1, 0, 1, 32'h0,        32'h80,       0, 32'h0,        0, 32'h80,       32'h4020D1B3, 0, 32'h108,      0};
    tbl[18] = '{0, 0, 0, 1, 1, 1, 32'h203,      32'h500,      0, 32'h0,        0, 32'h202,      32'h4020D1B3, 0, 32'h108,      0};
    tbl[19] = '{0, 0, 0, 1, 0, 1, 32'h0,        32'hFFFFFFFC, 0, 32'h0,        0, 32'hFFFFFFFC, 32'h4020D1B3, 0, 32'h108,      0};
    tbl[20] = '{0, 0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        32'h4020D1B3, 0, 32'h108,      0};

    for (int i = 0; i < 21; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Branch to a misaligned target, then fetch from it.
    step('{0, 0, 0, 1, 0, 1, 32'h0, 32'h102, 0, 32'h0, 0, 32'h102, 32'h4020D1B3, 0, 32'h108, 0}, "mis_pc");
`ifdef FETCH_MISALIGN_CHECK_EN
    step('{0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h102, 32'h4020D1B3, 0, 32'h108, 1}, "mis_fetch");
    step('{0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h102, 32'h4020D1B3, 0, 32'h108, 1}, "mis_stall");
`else
    step('{0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h102, 32'h4020D1B3, 1, 32'h100, 0}, "mis_fetch");
    step('{0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1, 32'h102, 32'h4020D1B3, 1, 32'h100, 0}, "mis_stall");
`endif

    // Reset mid-transaction: request drops, a late ack is ignored, IR stays NOP.
    step('{1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, NOP, 0, 32'h0, 0}, "rst_a");
    step('{0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, NOP, 1, 32'h0, 0}, "rst_req");
    step('{1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, NOP, 0, 32'h0, 0}, "rst_mid");
    step('{0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 1, 32'h00BADBAD, 1, 32'h0, NOP, 0, 32'h0, 0}, "rst_late_ack");
    step('{0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, NOP, 0, 32'h0, 0}, "rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the multicycle RV32I core, directly upstream of the control unit. Owns the program counter, issues word reads on the instruction bus, holds the fetched word in the instruction register, and presents the decode fields `opcode`, `f3` and `f7` to the control unit. It answers the control unit's fetch, load-IR and PC-advance strobes, and raises `stall` until instruction data is available.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: reset, synchronous, active-high.
- `fetch_req`  in  1: from the control unit's fetch-next-instruction strobe.
- `load_ir`  in  1: from the control unit's load-IR strobe.
- `pc_update`  in  1: from the control unit's PC-counter enable. One pulse per instruction.
- `pc_src`  in  1: 0 selects the sequential or branch path; 1 selects `alu_target` (JAL/JALR).
- `branch_taken`  in  1: branch condition result.
- `alu_target`  in  32: jump target from the ALU.
- `branch_target`  in  32: PC+imm from the datapath.
- `ibus_req`  out  1: read request.
- `ibus_addr`  out  32: word-aligned fetch address.
- `ibus_ack`  in  1: read data valid. May arrive in the same cycle as the request.
- `ibus_rdata`  in  32: read data.
- `stall`  out  1: to the control unit. Holds its state machine.
- `pc`  out  32: address of the instruction in `ir`.
- `next_pc`  out  32: `pc`+4, used for link writes.
- `ir`  out  32: instruction register.
- `opcode`  out  7: `ir[6:0]`.
- `f3`  out  3: `ir[14:12]`.
- `f7`  out  7: `ir[31:25]`.
- `fetch_fault`  out  1: misaligned fetch. Present only under the configuration macro.

## Operation
FSM states: IDLE, REQ, HOLD.
- **IDLE:**
  - `fetch_req`=1 → REQ.
  - On the same edge: `ibus_req`<=1 and `ibus_addr`<={`pc[31:2]`,2'b00}.
  - The address stays latched for the whole transaction.
- **REQ:**
  - `ibus_req` is held at 1 until `ibus_ack`.
  - On ack without `load_ir`: fetch buffer <= `ibus_rdata`, `ibus_req`<=0, → HOLD.
  - On ack with `load_ir` (bypass): `ir`<=`ibus_rdata`, `ibus_req`<=0, → IDLE.
- **HOLD:**
  - `load_ir`=1: `ir`<=buffer, → IDLE.
- `stall` = `load_ir` & !(state==HOLD | (state==REQ & `ibus_ack`)). `stall` is also asserted if `load_ir` arrives while in IDLE.
- **PC update** (on `pc_update`, any state):
  - `pc_src`=1: `pc`<={`alu_target[31:1]`,1'b0}.
  - else `branch_taken`=1: `pc`<=`branch_target`.
  - else: `pc`<=`pc`+4.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 = 0.
- A `pc_update` during an outstanding request does not alter the latched `ibus_addr`.
- `ibus_ack` while in IDLE or HOLD is ignored.
- **Reset** (synchronous, dominates all other inputs, including mid-transaction):
  - state=IDLE, `pc`=`RESET_PC`.
  - `ir`=32'h0000_0013 (NOP), so the decode fields are legal.
  - `ibus_req`=0, `ibus_addr`=0, buffer=0, `fetch_fault`=0.
  - `stall` is forced 0 while `rst`=1.

## Timing
- `ibus_req` is registered: it rises the cycle after `fetch_req` is sampled in IDLE.
- Zero-wait memory (ack in the first REQ cycle, coinciding with the control unit's LOAD_IR): `ir` updates one edge later, with no stall.
- N-cycle memory: `stall` is high for N cycles of LOAD_IR.
- `opcode`, `f3`, `f7` are combinational from `ir`. They are valid the cycle after the `load_ir` edge.
- `pc` and `next_pc` change on the edge after `pc_update`.
- `stall` is combinational from state, `load_ir` and `ibus_ack`.

## Configuration
`FETCH_MISALIGN_CHECK_EN`:
- **Defined:**
  - If `pc[1:0]`!=0 when `fetch_req` is sampled in IDLE, no bus request is issued.
  - `fetch_fault` goes to 1 and stays set until `rst`.
  - `stall` is held at 1 while `fetch_fault`=1.
- **Undefined:** `pc[1:0]` is ignored for addressing, and `fetch_fault` is tied to 0.

## Test plan
- **Reset:** `rst` high for 2 cycles → `pc`=`RESET_PC`, `ir`=32'h0000_0013, `opcode`=7'b0010011, `ibus_req`=0, `stall`=0.
- **Zero-wait fetch:** `fetch_req` for 1 cycle, then `load_ir` with same-cycle `ibus_ack`, `ibus_rdata`=32'h00500093 → `stall` never 1; `ir`=32'h00500093, `ibus_addr`=`RESET_PC`.
- **3-cycle memory latency:** `load_ir` held → `stall`=1 for exactly 3 cycles; `ir` loads on the ack edge; `ibus_req` is 0 after it.
- **PC sources:**
  - `pc`=0x100, `pc_update` with `pc_src`=0, `branch_taken`=0 → 0x104.
  - `branch_taken`=1, `branch_target`=0x80 → 0x80.
  - `pc_src`=1, `alu_target`=0x203 → 0x202.
  - `pc`=0xFFFFFFFC, sequential → 0.
- **Reset mid-transaction:** `rst` asserted in REQ before ack → `ibus_req`=0 next cycle; a later ack is ignored; `ir` stays NOP.
- **Misaligned fetch (macro defined):** `pc`=0x102, `fetch_req` → `ibus_req` stays 0, `fetch_fault`=1, `stall`=1 with `load_ir`.
